relu_backward: RTL
==================

Name: relu_backward

Overview:
- Backward-pass counterpart of the ReLU forward layer in the FPGA CNN datapath.
- Per lane: out_diff = top_diff when the saved forward input is > 0, else top_diff * NEG_SLOPE.
- Operates on WIDTH-lane vectors of IEEE-754 single-precision words.
- Fully pipelined: one vector per cycle, valid/ready handshake and stall-all backpressure. Sits between the upstream layer's gradient stream and the downstream gradient consumer.

Parameters:
- WIDTH, 8, number of 32-bit lanes per vector.
- NEG_SLOPE, 32'h00000000, negative slope as an IEEE-754 single bit pattern.
- PIPE_STAGES, 4, total input-to-output latency in cycles; legal range 2..8.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- clk_en  in  1  global enable; low freezes all state, outputs hold.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block accepts the input vector this cycle.
- in_data  in  32 x WIDTH  saved forward inputs (bottom data).
- in_diff  in  32 x WIDTH  incoming gradients (top diff).
- out_valid  out  1  output vector valid.
- out_ready  in  1  downstream accepts the output.
- out_diff  out  32 x WIDTH  outgoing gradients.

Behaviour:
- Reset (async, active-high) clears all stage valid bits, out_valid=0 and out_diff=0. in_ready=1 once reset deasserts and clk_en=1.
- Stage advance: adv = clk_en & (~out_valid | out_ready). in_ready = adv. A transfer occurs when in_valid & in_ready.
- Pipeline: PIPE_STAGES registered stages, each carrying a valid bit and per-lane data. On adv every stage shifts forward. Bubbles propagate as valid=0.
- Latency: an accepted vector appears on out_diff with out_valid=1 exactly PIPE_STAGES adv-cycles after acceptance.
- Stalls: while out_valid=1 and out_ready=0, or clk_en=0, no stage changes and out_diff holds stable.
- Positive test, registered in stage 1: pos = (sign==0) & (in_data[30:0] != 0).
  - +0, -0 and all negatives are not positive.
  - NaN with sign 0 counts as positive and passes its diff through.
- Pass-through path: the diff is delayed to match the multiply latency.
- Multiply path (fp_mult_pipe):
  - Denormal inputs flush to zero.
  - Result sign = XOR of input signs.
  - Exponent add with bias 127; mantissa product truncated (round toward zero).
  - Exponent overflow gives signed infinity; underflow gives signed zero.
  - Either operand NaN gives 32'h7FC00000. Inf * 0 gives 32'h7FC00000.
- Final select in the last stage: pos ? delayed diff : product.
- NEG_SLOPE==0: the product is +0 or -0 per the sign rule. Example: diff 3F800000 -> 00000000; diff BF800000 -> 80000000.
- Simultaneous in_valid and out_ready on a full pipe: input is accepted and output is retired in the same cycle, so throughput is 1 vector per cycle.
- Reset mid-stream: all in-flight vectors are discarded; no partial vector is ever emitted.

Optional Feature:
- Macro RELU_BWD_NAN_FLAG_EN.
- Defined: adds output nan_flag (1 bit). It is a sticky flag, set when any emitted lane equals a NaN pattern (exp==FF, mantissa!=0) on an output transfer. It is cleared only by reset.
- Not defined: the port and its logic are absent; datapath behaviour is identical.

Decomposition:
- Package relu_pkg holds:
  - typedef fp32_t (logic [31:0]);
  - constants FP32_QNAN=32'h7FC00000, FP32_EXP_BIAS=127;
  - function fp32_is_pos;
  - function fp32_is_nan.
- Sub-module fp_mult_pipe:
  - one lane, parameter STAGES = PIPE_STAGES-1, stall input adv;
  - instantiated WIDTH times inside a generate loop.

Test Plan:
- Slope 3F000000, in_data 3F800000, in_diff 40000000 -> out_diff 40000000 after 4 cycles.
- Slope 3F000000, in_data BF800000, in_diff 40000000 -> out_diff 3F800000; in_data 00000000 and 80000000 give the same result.
- Slope 00000000, in_data C0000000 in all lanes, in_diff BF800000 -> every lane 80000000.
- Streaming of 16 back-to-back vectors with out_ready toggling 1,0,0,1 -> outputs in order, no loss or duplication, out_diff stable while stalled. Also hold clk_en=0 for 3 cycles -> nothing moves.
- Slope 3F000000, in_diff 7F800000 with negative in_data -> 7F000000. in_diff 7FC00001 -> 7FC00000; with RELU_BWD_NAN_FLAG_EN, nan_flag rises on that transfer and stays high.
- Reset asserted with 3 vectors in flight -> out_valid=0 and out_diff=0 immediately. The next accepted vector emerges after exactly 4 cycles.

Source files
------------

// File: rtl/relu_backward_pkg.sv
// Shared FP32 types, constants and classification helpers for the ReLU
// backward datapath.
package relu_pkg;

   typedef logic [31:0] fp32_t;

   localparam fp32_t FP32_QNAN     = 32'h7FC00000;
   localparam int    FP32_EXP_BIAS = 127;

   // Strictly positive: sign clear and not +0 (a positive-sign NaN qualifies).
   function automatic logic fp32_is_pos(input fp32_t x);
      return ~x[31] & (x[30:0] != 31'd0);
   endfunction

   function automatic logic fp32_is_nan(input fp32_t x);
      return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
   endfunction

endpackage

// File: rtl/relu_backward_fp_mult_pipe.sv
// One-lane FP32 multiplier: flush-to-zero, truncating, result delayed by
// STAGES stall-controlled registers.
module fp_mult_pipe
   import relu_pkg::*;
#(
   parameter int STAGES = 3
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  adv_i,
   input  fp32_t a_i,
   input  fp32_t b_i,
   output fp32_t p_o
);

   logic               sp;
   logic               a_nan, b_nan, a_ff, b_ff, a_zero, b_zero;
   logic [24:0]        prod_hi;
   logic [22:0]        mant;
   logic signed [10:0] exp_s;
   fp32_t              p_d;
   fp32_t [STAGES-1:0] p_q;

   always_comb begin
      sp     = a_i[31] ^ b_i[31];
      a_ff   = (a_i[30:23] == 8'hFF);
      b_ff   = (b_i[30:23] == 8'hFF);
      a_nan  = fp32_is_nan(a_i);
      b_nan  = fp32_is_nan(b_i);
      a_zero = (a_i[30:23] == 8'h00);
      b_zero = (b_i[30:23] == 8'h00);
      // Only the top 25 bits of the 48-bit significand product matter.
      prod_hi = 25'((48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]})) >> 23);
      mant    = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
      exp_s   = $signed({3'b000, a_i[30:23]} + {3'b000, b_i[30:23]} + {10'd0, prod_hi[24]})
                - 11'(FP32_EXP_BIAS);
      // Infinity is not special-cased: it takes the normal exponent path.
      if (a_nan | b_nan | (a_ff & b_zero) | (b_ff & a_zero))
         p_d = FP32_QNAN;
      else if (a_zero | b_zero)
         p_d = {sp, 31'd0};
      else if (exp_s >= 11'sd255)
         p_d = {sp, 8'hFF, 23'd0};
      else if (exp_s <= 11'sd0)
         p_d = {sp, 31'd0};
      else
         p_d = {sp, exp_s[7:0], mant};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q <= '0;
      end else if (adv_i) begin
         p_q[0] <= p_d;
         for (int s = 1; s < STAGES; s++) p_q[s] <= p_q[s-1];
      end
   end

   assign p_o = p_q[STAGES-1];

endmodule

// File: rtl/relu_backward.sv
// ReLU backward layer: WIDTH FP32 lanes, PIPE_STAGES latency, stall-all flow
// control. Define RELU_BWD_NAN_FLAG_EN to add the sticky nan_flag output.
module relu_backward
   import relu_pkg::*;
#(
   parameter int          WIDTH       = 8,
   parameter logic [31:0] NEG_SLOPE   = 32'h00000000,
   parameter int          PIPE_STAGES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clk_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0][31:0] in_data,
   input  logic [WIDTH-1:0][31:0] in_diff,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0][31:0] out_diff
`ifdef RELU_BWD_NAN_FLAG_EN
   ,
   output logic                   nan_flag
`endif
);

   localparam int DLY = PIPE_STAGES - 1;

   logic                            adv;
   logic [PIPE_STAGES-1:0]          vld_q;
   logic [DLY-1:0][WIDTH-1:0]       pos_q;
   logic [DLY-1:0][WIDTH-1:0][31:0] diff_q;
   logic [WIDTH-1:0]                pos_d;
   logic [WIDTH-1:0][31:0]          prod, out_diff_d, out_diff_q;

   assign out_valid = vld_q[PIPE_STAGES-1];
   assign adv       = clk_en & (~out_valid | out_ready);
   assign in_ready  = adv;
   assign out_diff  = out_diff_q;

   for (genvar l = 0; l < WIDTH; l++) begin : g_lane
      assign pos_d[l] = fp32_is_pos(in_data[l]);

      fp_mult_pipe #(
         .STAGES (DLY)
      ) u_mult (
         .clk   (clk),
         .reset (reset),
         .adv_i (adv),
         .a_i   (in_diff[l]),
         .b_i   (NEG_SLOPE),
         .p_o   (prod[l])
      );

      assign out_diff_d[l] = pos_q[DLY-1][l] ? diff_q[DLY-1][l] : prod[l];
   end

   // Output data only loads on a valid vector so bubbles leave it untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q      <= '0;
         pos_q      <= '0;
         diff_q     <= '0;
         out_diff_q <= '0;
      end else if (adv) begin
         vld_q     <= {vld_q[PIPE_STAGES-2:0], in_valid};
         pos_q[0]  <= pos_d;
         diff_q[0] <= in_diff;
         for (int s = 1; s < DLY; s++) begin
            pos_q[s]  <= pos_q[s-1];
            diff_q[s] <= diff_q[s-1];
         end
         if (vld_q[PIPE_STAGES-2]) out_diff_q <= out_diff_d;
      end
   end

`ifdef RELU_BWD_NAN_FLAG_EN
   logic nan_flag_q;
   logic any_nan;

   always_comb begin
      any_nan = 1'b0;
      for (int l = 0; l < WIDTH; l++) any_nan |= fp32_is_nan(out_diff_q[l]);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         nan_flag_q <= 1'b0;
      else if (clk_en & out_valid & out_ready & any_nan)
         nan_flag_q <= 1'b1;
   end

   assign nan_flag = nan_flag_q;
`endif

endmodule
